pipe_bypass_chain: RTL and testbench
====================================

Name: pipe_bypass_chain

Overview:
- Parametrised in-order pipeline shell for the MIPS-CPU core.
- Carries DEPTH stages of result payload behind the issue point, each with a valid bit, a write-enable and a destination register.
- Resolves operand forwarding for NRD read ports, and raises a stall when a needed result is not yet produced, such as a load before its memory stage.
- Sits between decode and the regfile write port. It generalises fixed stage registers and 2-source bypass muxes to any depth, port count and late-result stage.

Parameters:
- DATA_W, 32, payload/result width
- REG_AW, 5, register address width
- DEPTH, 3, number of stages after issue (stage 0 youngest, DEPTH-1 = writeback); DEPTH >= 2
- NRD, 2, number of operand read ports
- LATE_STAGE, 1, stage whose late entries take late_data when leaving it; 0 <= LATE_STAGE <= DEPTH-2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  issue request
- in_ready  out  1  issue accepted this edge when in_valid & in_ready
- in_wr  in  1  entry writes a register
- in_addr  in  REG_AW  destination register
- in_data  in  DATA_W  early result (e.g. ALU)
- in_late  in  1  result produced at LATE_STAGE (load)
- flush  in  1  drop the issuing instruction
- rd_en  in  NRD  per-port operand needed
- rd_addr  in  NRD*REG_AW  source registers, port i at [i*REG_AW +: REG_AW]
- rd_regfile  in  NRD*DATA_W  regfile read values
- rd_data  out  NRD*DATA_W  forwarded operands
- stall  out  1  operand hazard, issue must hold
- late_valid  out  1  stage LATE_STAGE holds a valid late entry
- late_addr_data  out  DATA_W  data field of stage LATE_STAGE (memory address)
- late_data  in  DATA_W  late result, sampled on the edge that moves the entry on
- out_valid  out  1  stage DEPTH-1 valid
- out_wr  out  1  writeback enable (out_valid & stage wr)
- out_addr  out  REG_AW  writeback register
- out_data  out  DATA_W  writeback data

Behaviour:
- Each stage holds valid, wr, addr, data, late, and ok (result present).
- Reset (async, rst=1): all valid, wr, late and ok cleared, addr and data zeroed, immediately and not on a clock. Hence out_valid=0, out_wr=0, out_addr=0, out_data=0, late_valid=0, stall=0, in_ready=1.
- Advance: every edge, stage k moves to k+1 unconditionally, with no stall beyond the issue point. Stage DEPTH-1 retires.
- Late-result capture: when moving stage LATE_STAGE to LATE_STAGE+1, if the entry is late, data<=late_data and ok<=1. Otherwise data passes unchanged.
- Stage 0 load rules:
  - If in_valid & in_ready: stage 0 <= {1, in_wr, in_addr, in_data, in_late, !in_late}.
  - Otherwise stage 0 <= bubble (valid=0).
- Handshake: in_ready = !stall & !flush.
  - stall=1: bubble inserted and the issuer holds its instruction.
  - flush=1: the instruction is discarded; the issuer does not re-present it.
  - stall and flush together: flush wins, bubble, no hazard recorded.
- Latency: an entry accepted at edge E occupies stage k in the cycle after edge E+k. out_* show it in the cycle after E+DEPTH-1.
- Forwarding, per port i, combinational:
  - Scan stages 0..DEPTH-1 and take the youngest (lowest k) with valid & wr & addr==rd_addr[i].
  - Hit with ok=1: rd_data[i] = that stage's data.
  - Hit with ok=0: hazard_i=1 and rd_data[i] = rd_regfile[i] (don't-care).
  - No hit: rd_data[i] = rd_regfile[i].
  - Older matches behind a younger match are ignored, including when the younger match is not ok.
- stall = OR over i of (rd_en[i] & hazard_i). Ports with rd_en=0 never stall but still drive rd_data.
- A dependent instruction immediately after a late producer stalls LATE_STAGE+1 cycles.
- Writeback at stage DEPTH-1 is forwarded, so same-cycle regfile write-through is not required.
- Reset asserted mid-stream: all in-flight entries are lost. No writeback is issued after rst deasserts until new issues propagate.

Optional Feature:
- Macro PIPE_R0_ZERO_EN.
- Defined: register address 0 never matches any stage, never raises a hazard, and rd_data[i] is forced to 0 when rd_addr[i]==0. out_wr is forced 0 when out_addr==0.
- Undefined: address 0 is treated like any other register, matched, forwarded and written back.

Test Plan:
- Defaults, PIPE_R0_ZERO_EN undefined unless stated.
- rst pulsed asynchronously between edges while 3 entries are in flight -> out_valid, late_valid and stall drop to 0 before the next edge; out_data=0.
- Issue wr r5=0x00000011, then a read r5 on port 0 the next cycle -> stall=0 and rd_data[0]=0x00000011 (stage 0 hit). After 3 edges out_wr=1, out_addr=5, out_data=0x11.
- Issue wr r5=0x11, then wr r5=0x22, then read r5 -> rd_data[0]=0x22 (youngest wins).
- Issue late wr r6, late_data=0xABCD0000 when it is in stage 1; read r6 on port 1 next cycle -> stall=1 for 2 cycles with in_ready=0, then rd_data[1]=0xABCD0000 and stall=0.
- Late r6 in flight, reader uses r6 on port 1 with rd_en[1]=0 -> stall=0, and rd_data[1] is the regfile value.
- flush=1 with in_valid=1 (wr r7=0x55) -> in_ready=0, no out_wr for r7 ever. With PIPE_R0_ZERO_EN defined, issue wr r0=0x99 then read r0 -> rd_data=0, out_wr=0 at writeback.

Source files
------------

// File: rtl/pipe_bypass_chain_if.sv
// pipe_bypass_chain_if
// Bundles the issue handshake, operand read ports, late-result port and
// writeback port of pipe_bypass_chain.
//   master : decode/issue side (drives requests, operands, late data)
//   slave  : the pipeline shell itself
// Handshake: an issue is taken on a rising clk edge exactly when
// in_valid & in_ready are both high in the cycle before it. in_ready is
// low while an operand hazard stalls or while flush drops the instruction.
// When stalled the issuer keeps presenting the same instruction. When
// flushed the issuer does not present it again.
interface pipe_bypass_chain_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int NRD    = 2
);
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_wr;
   logic [REG_AW-1:0]        in_addr;
   logic [DATA_W-1:0]        in_data;
   logic                     in_late;
   logic                     flush;
   logic [NRD-1:0]           rd_en;
   logic [NRD*REG_AW-1:0]    rd_addr;
   logic [NRD*DATA_W-1:0]    rd_regfile;
   logic [NRD*DATA_W-1:0]    rd_data;
   logic                     stall;
   logic                     late_valid;
   logic [DATA_W-1:0]        late_addr_data;
   logic [DATA_W-1:0]        late_data;
   logic                     out_valid;
   logic                     out_wr;
   logic [REG_AW-1:0]        out_addr;
   logic [DATA_W-1:0]        out_data;

   modport master (
      output in_valid, in_wr, in_addr, in_data, in_late, flush,
             rd_en, rd_addr, rd_regfile, late_data,
      input  in_ready, rd_data, stall, late_valid, late_addr_data,
             out_valid, out_wr, out_addr, out_data
   );

   modport slave (
      input  in_valid, in_wr, in_addr, in_data, in_late, flush,
             rd_en, rd_addr, rd_regfile, late_data,
      output in_ready, rd_data, stall, late_valid, late_addr_data,
             out_valid, out_wr, out_addr, out_data
   );
endinterface

// File: rtl/pipe_bypass_chain.sv
// pipe_bypass_chain
// In-order pipeline shell: DEPTH result stages behind the issue point,
// operand forwarding for NRD read ports, and a stall when a needed result
// is not produced yet (a late/load entry before it leaves LATE_STAGE).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pipe_bypass_chain_if.slave. It carries the issue handshake
//              (in_*, flush), the read ports (rd_*, stall), the late-result
//              port (late_*) and the writeback port (out_*).
// Optional build macro PIPE_R0_ZERO_EN: register 0 is hardwired to zero.
// It never matches, never stalls, reads as 0 and is never written back.
module pipe_bypass_chain #(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int NRD        = 2,
   parameter int LATE_STAGE = 1
) (
   input logic                clk,
   input logic                rst,
   pipe_bypass_chain_if.slave bus
);

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              late;
      logic              ok;     // result present in data
   } stage_t;

   stage_t st [DEPTH];

   logic [NRD-1:0]    hazard;
   logic [REG_AW-1:0] raddr;
   logic              hit;
   logic              hit_ok;
   logic [DATA_W-1:0] hit_data;
   logic              accept;

   function automatic logic stage_match(stage_t s, logic [REG_AW-1:0] a);
`ifdef PIPE_R0_ZERO_EN
      return s.valid && s.wr && (s.addr == a) && (a != '0);
`else
      return s.valid && s.wr && (s.addr == a);
`endif
   endfunction

   assign bus.stall    = |(bus.rd_en & hazard);
   assign bus.in_ready = !bus.stall && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // Stages advance every edge. Only the issue point can hold, and it
   // holds by loading a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            st[k] <= '0;
         end
      end else begin
         if (accept) begin
            st[0] <= '{valid: 1'b1, wr: bus.in_wr, addr: bus.in_addr,
                       data: bus.in_data, late: bus.in_late, ok: !bus.in_late};
         end else begin
            st[0] <= '0;
         end
         for (int k = 1; k < DEPTH; k++) begin
            st[k] <= st[k-1];
            // A late entry picks up its result as it leaves LATE_STAGE.
            if ((k - 1 == LATE_STAGE) && st[k-1].valid && st[k-1].late) begin
               st[k].data <= bus.late_data;
               st[k].ok   <= 1'b1;
            end
         end
      end
   end

   // Forwarding: the scan runs from oldest to youngest, so the last match
   // written is the youngest one. Its ok bit alone decides hit or hazard.
   // Older ok copies behind a pending younger write must not be used.
   always_comb begin
      hazard      = '0;
      raddr       = '0;
      hit         = 1'b0;
      hit_ok      = 1'b0;
      hit_data    = '0;
      bus.rd_data = bus.rd_regfile;
      for (int i = 0; i < NRD; i++) begin
         raddr    = bus.rd_addr[i*REG_AW +: REG_AW];
         hit      = 1'b0;
         hit_ok   = 1'b0;
         hit_data = '0;
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (stage_match(st[k], raddr)) begin
               hit      = 1'b1;
               hit_ok   = st[k].ok;
               hit_data = st[k].data;
            end
         end
         if (hit && hit_ok) begin
            bus.rd_data[i*DATA_W +: DATA_W] = hit_data;
         end
         hazard[i] = hit && !hit_ok;
`ifdef PIPE_R0_ZERO_EN
         if (raddr == '0) begin
            bus.rd_data[i*DATA_W +: DATA_W] = '0;
         end
`endif
      end
   end

   assign bus.late_valid     = st[LATE_STAGE].valid && st[LATE_STAGE].late;
   assign bus.late_addr_data = st[LATE_STAGE].data;

   assign bus.out_valid = st[DEPTH-1].valid;
   assign bus.out_addr  = st[DEPTH-1].addr;
   assign bus.out_data  = st[DEPTH-1].data;
`ifdef PIPE_R0_ZERO_EN
   assign bus.out_wr = st[DEPTH-1].valid && st[DEPTH-1].wr && (st[DEPTH-1].addr != '0);
`else
   assign bus.out_wr = st[DEPTH-1].valid && st[DEPTH-1].wr;
`endif

endmodule

// File: tb/tb_pipe_bypass_chain.sv
// tb_pipe_bypass_chain
// Directed steps followed by randomized issue traffic. The reference model
// records the instruction accepted at every edge. From the age of each
// record it derives the stage the record occupies, its forwarding
// visibility and its writeback. A queue holds the expected writebacks.
module tb_pipe_bypass_chain;
   localparam int DATA_W     = 32;
   localparam int REG_AW     = 5;
   localparam int DEPTH      = 3;
   localparam int NRD        = 2;
   localparam int LATE_STAGE = 1;
   localparam int MAXC       = 2048;

   typedef struct packed {
      logic              v;
      logic              wr;
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              late;
      logic [DATA_W-1:0] late_val;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int passed   = 0;
   int cyc      = 0;
   int base_cyc = 1;
   logic acc_exp = 1'b0;

   ent_t log_e [MAXC];
   ent_t cur;
   logic [REG_AW+DATA_W-1:0] exp_q [$];

   pipe_bypass_chain_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NRD(NRD)) bus ();

   pipe_bypass_chain #(
      .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .NRD(NRD), .LATE_STAGE(LATE_STAGE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // The entry issued at edge c sits in stage (cyc - c).
   function automatic ent_t at_stage(int k);
      int c;
      c = cyc - k;
      if (c < base_cyc) return '0;
      return log_e[c];
   endfunction

   function automatic logic r0_ok(logic [REG_AW-1:0] a);
`ifdef PIPE_R0_ZERO_EN
      return a != '0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic cycle_check();
      ent_t e;
      logic stl;
      logic found, ok;
      logic [REG_AW-1:0] ra;
      logic [DATA_W-1:0] val, exp;
      logic [REG_AW+DATA_W-1:0] wb;
      stl = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         ra    = bus.rd_addr[i*REG_AW +: REG_AW];
         found = 1'b0;
         ok    = 1'b0;
         val   = '0;
         for (int k = 0; k < DEPTH; k++) begin
            e = at_stage(k);
            if (!found && e.v && e.wr && e.addr == ra && r0_ok(ra)) begin
               found = 1'b1;
               ok    = !e.late || (k > LATE_STAGE);
               val   = e.late ? e.late_val : e.data;
            end
         end
         exp = (found && ok) ? val : bus.rd_regfile[i*DATA_W +: DATA_W];
         if (!r0_ok(ra)) exp = '0;
         chk($sformatf("rd_data%0d", i), bus.rd_data[i*DATA_W +: DATA_W], exp);
         if (bus.rd_en[i] && found && !ok) stl = 1'b1;
      end
      chk("stall", {31'b0, bus.stall}, {31'b0, stl});
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !stl && !bus.flush});
      acc_exp = bus.in_valid && !stl && !bus.flush;

      e = at_stage(LATE_STAGE);
      chk("late_valid", {31'b0, bus.late_valid}, {31'b0, e.v && e.late});
      if (e.v && e.late) chk("late_addr_data", bus.late_addr_data, e.data);

      e = at_stage(DEPTH - 1);
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, e.v});
      chk("out_wr", {31'b0, bus.out_wr}, {31'b0, e.v && e.wr && r0_ok(e.addr)});
      if (e.v) begin
         chk("out_addr", {27'b0, bus.out_addr}, {27'b0, e.addr});
         chk("out_data", bus.out_data, e.late ? e.late_val : e.data);
      end
      if (bus.out_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", {31'b0, bus.out_wr}, 32'd0);
         end else begin
            wb = exp_q.pop_front();
            chk("wb_q_addr", {27'b0, bus.out_addr}, {27'b0, wb[DATA_W +: REG_AW]});
            chk("wb_q_data", bus.out_data, wb[DATA_W-1:0]);
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic iv, input logic iw, input logic [REG_AW-1:0] ia,
                        input logic [DATA_W-1:0] id, input logic il, input logic [DATA_W-1:0] lv,
                        input logic fl, input logic [NRD-1:0] ren,
                        input logic [REG_AW-1:0] ra0, input logic [REG_AW-1:0] ra1);
      ent_t e;
      logic [DATA_W-1:0] r0v, r1v;
      r0v = $urandom;
      r1v = $urandom;
      cur = '{v: iv, wr: iw, addr: ia, data: id, late: il, late_val: lv};
      bus.in_valid   = iv;
      bus.in_wr      = iw;
      bus.in_addr    = ia;
      bus.in_data    = id;
      bus.in_late    = il;
      bus.flush      = fl;
      bus.rd_en      = ren;
      bus.rd_addr    = {ra1, ra0};
      bus.rd_regfile = {r1v, r0v};
      e = at_stage(LATE_STAGE);
      bus.late_data  = (e.v && e.late) ? e.late_val : $urandom;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0);
   endtask

   // Check at the falling edge, then commit the model at the rising edge.
   task automatic step();
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      cyc++;
      log_e[cyc] = acc_exp ? cur : '0;
      if (acc_exp && cur.wr && r0_ok(cur.addr))
         exp_q.push_back({cur.addr, cur.late ? cur.late_val : cur.data});
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic pend;
      idle();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_out_wr", {31'b0, bus.out_wr}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_late_valid", {31'b0, bus.late_valid}, 32'd0);
      chk("rst_stall", {31'b0, bus.stall}, 32'd0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      base_cyc = cyc + 1;

      // write r5 then read it from stage 0
      drive(1, 1, 5, 32'h11, 0, 0, 0, 2'b00, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0); #1;
      chk("fwd_stage0", bus.rd_data[31:0], 32'h11);
      chk("fwd_stage0_stall", {31'b0, bus.stall}, 32'd0);
      step();
      idle(); step();
      idle(); #1;
      chk("wb_r5_wr", {31'b0, bus.out_wr}, 32'd1);
      chk("wb_r5_addr", {27'b0, bus.out_addr}, 32'd5);
      chk("wb_r5_data", bus.out_data, 32'h11);
      step();

      // youngest of two writers wins
      drive(1, 1, 5, 32'h11, 0, 0, 0, 2'b00, 0, 0); step();
      drive(1, 1, 5, 32'h22, 0, 0, 0, 2'b00, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0); #1;
      chk("youngest_wins", bus.rd_data[31:0], 32'h22);
      step();

      // late producer r6, dependent reader on port 1
      drive(1, 1, 6, 32'h100, 1, 32'hABCD0000, 0, 2'b00, 0, 0); step();
      for (int n = 0; n < 2; n++) begin
         drive(1, 1, 7, 32'h33, 0, 0, 0, 2'b10, 0, 6); #1;
         chk("late_stall", {31'b0, bus.stall}, 32'd1);
         chk("late_in_ready", {31'b0, bus.in_ready}, 32'd0);
         step();
      end
      drive(1, 1, 7, 32'h33, 0, 0, 0, 2'b10, 0, 6); #1;
      chk("late_fwd", bus.rd_data[63:32], 32'hABCD0000);
      chk("late_released", {31'b0, bus.stall}, 32'd0);
      step();

      // late r6 in flight, port 1 not enabled
      drive(1, 1, 6, 32'h200, 1, 32'h12345678, 0, 2'b00, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 6); #1;
      chk("rd_en0_stall", {31'b0, bus.stall}, 32'd0);
      chk("rd_en0_regfile", bus.rd_data[63:32], bus.rd_regfile[63:32]);
      step();
      for (int n = 0; n < 4; n++) begin idle(); step(); end

      // flushed issue never writes back
      drive(1, 1, 7, 32'h55, 0, 0, 1, 2'b00, 0, 0); #1;
      chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
      step();
      for (int n = 0; n < 2; n++) begin idle(); step(); end
      idle(); #1;
      chk("flush_no_wb", {31'b0, bus.out_wr}, 32'd0);
      step();

`ifdef PIPE_R0_ZERO_EN
      drive(1, 1, 0, 32'h99, 0, 0, 0, 2'b00, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0); #1;
      chk("r0_read_zero", bus.rd_data[31:0], 32'd0);
      step();
      idle(); #1;
      chk("r0_no_wb", {31'b0, bus.out_wr}, 32'd0);
      step();
`endif

      // asynchronous reset with entries in flight
      drive(1, 1, 8, 32'h1, 0, 0, 0, 2'b00, 0, 0); step();
      drive(1, 1, 9, 32'h2, 1, 32'h3, 0, 2'b00, 0, 0); step();
      drive(1, 1, 10, 32'h4, 0, 0, 0, 2'b00, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 2'b01, 9, 0); #1;
      chk("pre_rst_stall", {31'b0, bus.stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("mid_rst_late_valid", {31'b0, bus.late_valid}, 32'd0);
      chk("mid_rst_stall", {31'b0, bus.stall}, 32'd0);
      chk("mid_rst_out_data", bus.out_data, 32'd0);
      rst = 1'b0;
      base_cyc = cyc + 1;
      exp_q.delete();
      step();
      for (int n = 0; n < 3; n++) begin idle(); step(); end

      // randomized traffic; a stalled issuer keeps its instruction
      pend = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (pend) begin
            drive(cur.v, cur.wr, cur.addr, cur.data, cur.late, cur.late_val,
                  ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         end else begin
            drive(($urandom_range(0, 9) < 7), 1'($urandom), 5'($urandom_range(0, 3)),
                  $urandom, ($urandom_range(0, 9) < 3), $urandom,
                  ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         end
         step();
         pend = cur.v && !acc_exp && !bus.flush;
      end
      for (int n = 0; n < DEPTH + 1; n++) begin idle(); step(); end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
